// File: rtl/qpu_exu_decode_fifo_if.sv
// Fetch/dispatch bus of the QPU decode FIFO: instruction in, decoded head record out.
// The slave modport is the decode stage's view of the bus; master is the fetch/dispatch side.
interface qpu_exu_decode_fifo_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int TP_W  = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              i_valid;
   logic              i_ready;
   logic [31:0]       i_instr;
   logic [PC_W-1:0]   i_pc;
   logic              i_prdt_taken;
   logic              flush;

   logic              o_valid;
   logic              o_ready;
   logic [31:0]       o_instr;
   logic [PC_W-1:0]   o_pc;
   logic              o_prdt_taken;
   logic [8:0]        o_class;
   logic [5:0]        o_rs1idx;
   logic [5:0]        o_rs2idx;
   logic [5:0]        o_rdidx;
   logic              o_rs1en;
   logic              o_rs2en;
   logic              o_rdwen;
   logic              o_new_timepoint;
   logic              o_measure;
   logic              o_fmr;
   logic              o_illegal;
   logic [TP_W-1:0]   o_tp_label;
   logic [CNT_W-1:0]  o_count;

   modport slave (
      input  i_valid, i_instr, i_pc, i_prdt_taken, flush, o_ready,
      output i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_class,
             o_rs1idx, o_rs2idx, o_rdidx, o_rs1en, o_rs2en, o_rdwen,
             o_new_timepoint, o_measure, o_fmr, o_illegal, o_tp_label, o_count
   );

   modport master (
      output i_valid, i_instr, i_pc, i_prdt_taken, flush, o_ready,
      input  i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_class,
             o_rs1idx, o_rs2idx, o_rdidx, o_rs1en, o_rs2en, o_rdwen,
             o_new_timepoint, o_measure, o_fmr, o_illegal, o_tp_label, o_count
   );
endinterface

// File: rtl/qpu_exu_decode_fifo.sv
// QPU execution-unit decode stage: combinational decode of classical/quantum instructions
// into a DEPTH-entry FIFO, with flush, illegal detection and a running timepoint label.
module qpu_exu_decode_fifo #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 32,
   parameter int TP_W    = 8,
   parameter bit QDEC_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   qpu_exu_decode_fifo_if.slave  io
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic            prdt_taken;
      logic [8:0]      cls;
      logic [5:0]      rs1idx;
      logic [5:0]      rs2idx;
      logic [5:0]      rdidx;
      logic            rs1en;
      logic            rs2en;
      logic            rdwen;
      logic            new_tp;
      logic            measure;
      logic            fmr;
      logic            illegal;
   } rec_t;

   // ---------------- decode ----------------
   logic       is_q;
   logic [4:0] opc;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [2:0] func3;
   logic [8:0] op1;
   logic [8:0] op2;
   logic       c_load, c_store, c_branch, c_opimm, c_op, c_qwait, c_fmr, c_smis;
   logic       legal;
   logic [8:0] cls;
   rec_t       dec;

   always_comb begin
      is_q  = io.i_instr[0];
      opc   = io.i_instr[4:0];
      rd    = io.i_instr[9:5];
      rs1   = io.i_instr[14:10];
      rs2   = io.i_instr[28:24];
      func3 = io.i_instr[31:29];
      op1   = io.i_instr[9:1];
      op2   = io.i_instr[23:15];

      c_load   = ~is_q & (opc == 5'b00000);
      c_store  = ~is_q & (opc == 5'b01000);
      c_branch = ~is_q & (opc == 5'b11000);
      c_opimm  = ~is_q & (opc == 5'b00010);
      c_op     = ~is_q & (opc == 5'b01010);
      c_qwait  = ~is_q & (opc == 5'b10010);
      c_fmr    = ~is_q & (opc == 5'b11010);
      c_smis   = ~is_q & (opc == 5'b00110);

      // func3 qualifies legality of branch/op_imm/op; the upper op encodings are reserved
      if (is_q) begin
         legal = QDEC_EN;
      end else begin
         legal = c_load | c_store | c_qwait | c_fmr | c_smis
               | ((c_branch | c_opimm) & (func3 <= 3'd3))
               | (c_op & (func3 <= 3'd4));
      end

      cls = legal ? {is_q, c_smis, c_fmr, c_qwait, c_op, c_opimm, c_branch, c_store, c_load}
                  : 9'h000;

      dec            = '0;
      dec.instr      = io.i_instr;
      dec.pc         = io.i_pc;
      dec.prdt_taken = io.i_prdt_taken;
      dec.cls        = cls;
      dec.rs1idx     = {cls[6] | cls[8], rs1};
      dec.rs2idx     = {cls[8], rs2};
      dec.rdidx      = {cls[7], rd};
      dec.rs1en      = (rs1 != 5'd0) & legal & ~cls[5] & ~cls[7];
      dec.rs2en      = (rs2 != 5'd0)
                     & (cls[2] | cls[1] | cls[4] | cls[6] | (cls[8] & (op2 != 9'd0)));
      dec.rdwen      = (rd != 5'd0) & (cls[0] | cls[3] | cls[4] | cls[6] | cls[7]);
      dec.new_tp     = cls[5] | (cls[8] & (func3 != 3'd0));
      dec.measure    = cls[8] & (op1 == 9'h1FF);
      dec.fmr        = cls[6];
      dec.illegal    = ~legal;
   end

   // ---------------- FIFO and timepoint counter ----------------
   rec_t             mem_q [DEPTH];
   rec_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TP_W-1:0]  tp_q, tp_d;

   logic             full;
   logic             push;
   logic             pop;
   rec_t             head;
   logic [TP_W-1:0]  tp_label;

   always_comb begin
      full     = (cnt_q == CNT_W'(DEPTH));
      head     = mem_q[rd_ptr_q];
      tp_label = tp_q + TP_W'(head.new_tp);

      io.i_ready         = ~full & ~rst;
      io.o_valid         = (cnt_q != '0);
      io.o_instr         = head.instr;
      io.o_pc            = head.pc;
      io.o_prdt_taken    = head.prdt_taken;
      io.o_class         = head.cls;
      io.o_rs1idx        = head.rs1idx;
      io.o_rs2idx        = head.rs2idx;
      io.o_rdidx         = head.rdidx;
      io.o_rs1en         = head.rs1en;
      io.o_rs2en         = head.rs2en;
      io.o_rdwen         = head.rdwen;
      io.o_new_timepoint = head.new_tp;
      io.o_measure       = head.measure;
      io.o_fmr           = head.fmr;
      io.o_illegal       = head.illegal;
      io.o_tp_label      = tp_label;
      io.o_count         = cnt_q;
   end

   always_comb begin
      push     = io.i_valid & ~full & ~rst;
      pop      = (cnt_q != '0) & io.o_ready;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      tp_d     = tp_q;

      // flush swallows any push/pop of the same cycle and leaves the timepoint alone
      if (io.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = dec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            tp_d     = tp_label;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         tp_q     <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         tp_q     <= tp_d;
      end
   end
endmodule

// File: tb/tb_qpu_exu_decode_fifo.sv
// Bench for qpu_exu_decode_fifo: hand-decoded vector table fed through a scoreboard,
// plus fill, timepoint, flush, reset and QDEC_EN=0 sequences.
module tb_qpu_exu_decode_fifo;
   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int TP_W  = 8;
   localparam int NV    = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qpu_exu_decode_fifo_if #(.DEPTH(DEPTH), .PC_W(PC_W), .TP_W(TP_W)) f ();
   qpu_exu_decode_fifo_if #(.DEPTH(DEPTH), .PC_W(PC_W), .TP_W(TP_W)) g ();

   qpu_exu_decode_fifo #(.DEPTH(DEPTH), .PC_W(PC_W), .TP_W(TP_W), .QDEC_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .io(f));
   qpu_exu_decode_fifo #(.DEPTH(DEPTH), .PC_W(PC_W), .TP_W(TP_W), .QDEC_EN(1'b0)) dut_nq (
      .clk(clk), .rst(rst), .io(g));

   typedef struct {
      logic [31:0] instr;
      logic [8:0]  cls;
      logic [5:0]  rs1idx;
      logic [5:0]  rs2idx;
      logic [5:0]  rdidx;
      logic [2:0]  en;   // {rs1en, rs2en, rdwen}
      logic [3:0]  fl;   // {new_timepoint, measure, fmr, illegal}
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] pc;
      logic        prdt;
   } sb_t;

   vec_t            vec [NV];
   sb_t             sb [$];
   sb_t             cur;
   logic [TP_W-1:0] tp_model = '0;
   logic [31:0]     pc_ctr   = 32'h0000_1000;
   int              errors   = 0;
   int              checks   = 0;

   function automatic logic [31:0] mk_c(logic [2:0] f3, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [4:0] rd, logic [4:0] opc);
      return {f3, rs2, 9'h000, rs1, rd, opc};
   endfunction

   function automatic logic [31:0] mk_q(logic [2:0] pi, logic [4:0] rs2, logic [8:0] op2,
                                        logic [4:0] rs1, logic [8:0] op1);
      return {pi, rs2, op2, rs1, op1, 1'b1};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic cmp(sb_t e);
      logic [TP_W-1:0] lbl;
      lbl = tp_model + TP_W'(e.v.fl[3]);
      chk("instr",    f.o_instr, e.v.instr);
      chk("pc",       f.o_pc, e.pc);
      chk("prdt",     f.o_prdt_taken, e.prdt);
      chk("class",    f.o_class, e.v.cls);
      chk("rs1idx",   f.o_rs1idx, e.v.rs1idx);
      chk("rs2idx",   f.o_rs2idx, e.v.rs2idx);
      chk("rdidx",    f.o_rdidx, e.v.rdidx);
      chk("enables",  {f.o_rs1en, f.o_rs2en, f.o_rdwen}, e.v.en);
      chk("flags",    {f.o_new_timepoint, f.o_measure, f.o_fmr, f.o_illegal}, e.v.fl);
      chk("tp_label", f.o_tp_label, lbl);
      tp_model = lbl;
   endtask

   task automatic drive(int r);
      f.i_valid      = 1'b1;
      f.i_instr      = vec[r].instr;
      f.i_pc         = pc_ctr;
      f.i_prdt_taken = 1'($urandom_range(0, 1));
      cur.v          = vec[r];
      cur.pc         = pc_ctr;
      cur.prdt       = f.i_prdt_taken;
      pc_ctr         = pc_ctr + 32'd4;
   endtask

   // entered at posedge+1; observes the settled cycle, then advances to the next posedge+1
   task automatic tick();
      #2;
      if (rst) begin
         sb.delete();
         tp_model = '0;
      end else if (f.flush) begin
         sb.delete();
      end else begin
         if (f.o_valid && f.o_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop act=1 exp=0");
            end else begin
               cmp(sb.pop_front());
            end
         end
         if (f.i_valid && f.i_ready) sb.push_back(cur);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      f.i_valid = 1'b0;
      f.o_ready = 1'b1;
      for (int n = 0; n < 16 && f.o_valid; n++) tick();
      chk("drain_count", f.o_count, 0);
      chk("drain_sb_left", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TP_W-1:0] tp_exp [4];

      vec[0]  = '{mk_c(3'd0, 5'd0, 5'd5, 5'd3,  5'b00010), 9'h008, 6'h05, 6'h00, 6'h03, 3'b101, 4'b0000};
      vec[1]  = '{mk_c(3'd2, 5'd0, 5'd7, 5'd4,  5'b00000), 9'h001, 6'h07, 6'h00, 6'h04, 3'b101, 4'b0000};
      vec[2]  = '{mk_c(3'd2, 5'd9, 5'd7, 5'd0,  5'b01000), 9'h002, 6'h07, 6'h09, 6'h00, 3'b110, 4'b0000};
      vec[3]  = '{mk_c(3'd3, 5'd2, 5'd1, 5'd0,  5'b11000), 9'h004, 6'h01, 6'h02, 6'h00, 3'b110, 4'b0000};
      vec[4]  = '{mk_c(3'd4, 5'd6, 5'd5, 5'd10, 5'b01010), 9'h010, 6'h05, 6'h06, 6'h0A, 3'b111, 4'b0000};
      vec[5]  = '{mk_c(3'd0, 5'd0, 5'd3, 5'd0,  5'b10010), 9'h020, 6'h03, 6'h00, 6'h00, 3'b000, 4'b1000};
      vec[6]  = '{mk_c(3'd0, 5'd4, 5'd2, 5'd8,  5'b11010), 9'h040, 6'h22, 6'h04, 6'h08, 3'b111, 4'b0010};
      vec[7]  = '{mk_c(3'd0, 5'd0, 5'd1, 5'd7,  5'b00110), 9'h080, 6'h01, 6'h00, 6'h27, 3'b001, 4'b0000};
      vec[8]  = '{mk_q(3'd0, 5'd3, 9'h005, 5'd4, 9'h010),  9'h100, 6'h24, 6'h23, 6'h01, 3'b110, 4'b0000};
      vec[9]  = '{mk_q(3'd2, 5'd0, 9'h000, 5'd0, 9'h020),  9'h100, 6'h20, 6'h20, 6'h02, 3'b000, 4'b1000};
      vec[10] = '{mk_q(3'd0, 5'd1, 9'h003, 5'd2, 9'h1FF),  9'h100, 6'h22, 6'h21, 6'h1F, 3'b110, 4'b0100};
      vec[11] = '{mk_c(3'd0, 5'd1, 5'd1, 5'd1,  5'b00100), 9'h000, 6'h01, 6'h01, 6'h01, 3'b000, 4'b0001};
      vec[12] = '{mk_c(3'd5, 5'd1, 5'd2, 5'd3,  5'b01010), 9'h000, 6'h02, 6'h01, 6'h03, 3'b000, 4'b0001};
      vec[13] = '{mk_c(3'd4, 5'd0, 5'd1, 5'd1,  5'b00010), 9'h000, 6'h01, 6'h00, 6'h01, 3'b000, 4'b0001};
      vec[14] = '{mk_c(3'd7, 5'd1, 5'd1, 5'd0,  5'b11000), 9'h000, 6'h01, 6'h01, 6'h00, 3'b000, 4'b0001};
      tp_exp  = '{8'd1, 8'd1, 8'd2, 8'd2};

      f.i_valid = 0; f.i_instr = '0; f.i_pc = '0; f.i_prdt_taken = 0; f.flush = 0; f.o_ready = 0;
      g.i_valid = 0; g.i_instr = '0; g.i_pc = '0; g.i_prdt_taken = 0; g.flush = 0; g.o_ready = 0;

      // reset state
      @(posedge clk); #1;
      tick();
      chk("rst_i_ready", f.i_ready, 0);
      rst = 1'b0;
      #1;
      chk("reset_i_ready", f.i_ready, 1);
      chk("reset_o_valid", f.o_valid, 0);
      chk("reset_count", f.o_count, 0);
      chk("reset_tp_label", f.o_tp_label, 0);
      chk("reset_record", {f.o_instr, f.o_pc, f.o_class, f.o_rs1idx, f.o_rs2idx, f.o_rdidx}, 0);
      chk("reset_flags", {f.o_prdt_taken, f.o_rs1en, f.o_rs2en, f.o_rdwen,
                          f.o_new_timepoint, f.o_measure, f.o_fmr, f.o_illegal}, 0);

      // first push latency, no bypass
      drive(0);
      #1;
      chk("no_bypass_o_valid", f.o_valid, 0);
      tick();
      f.i_valid = 1'b0;
      chk("latency_o_valid", f.o_valid, 1);
      chk("latency_count", f.o_count, 1);
      chk("addi_class", f.o_class, 9'h008);
      drain();

      // vector table streamed with simultaneous push/pop
      f.o_ready = 1'b1;
      for (int r = 0; r < NV; r++) begin
         drive(r);
         tick();
         chk("stream_count", f.o_count, 1);
      end
      drain();

      // fill to DEPTH with dispatch stalled, fifth held at fetch
      rst = 1'b1; tick(); rst = 1'b0;
      f.o_ready = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
         drive(r + 1);
         tick();
      end
      chk("full_i_ready", f.i_ready, 0);
      chk("full_count", f.o_count, 4);
      drive(5);
      tick();
      chk("held_count", f.o_count, 4);
      f.o_ready = 1'b1;
      #1;
      chk("pop_cycle_i_ready", f.i_ready, 0);
      tick();
      f.o_ready = 1'b0;
      chk("after_pop_i_ready", f.i_ready, 1);
      chk("after_pop_count", f.o_count, 3);
      tick();
      f.i_valid = 1'b0;
      chk("refill_count", f.o_count, 4);
      drain();

      // timepoint labels: qwait, quantum PI=0, quantum PI=2, measure
      rst = 1'b1; tick(); rst = 1'b0;
      f.o_ready = 1'b0;
      drive(5); tick();
      drive(8); tick();
      drive(9); tick();
      drive(10); tick();
      f.i_valid = 1'b0;
      f.o_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("tp_seq_label", f.o_tp_label, tp_exp[k]);
         if (k == 3) chk("measure_bits", {f.o_measure, f.o_rs1idx[5], f.o_rs2idx[5]}, 3'b111);
         tick();
      end
      chk("tp_seq_empty", f.o_valid, 0);

      // flush with 3 buffered and a concurrent push/pop
      f.o_ready = 1'b0;
      drive(5); tick();
      drive(9); tick();
      drive(0); tick();
      chk("preflush_count", f.o_count, 3);
      f.flush = 1'b1;
      f.o_ready = 1'b1;
      drive(1);
      tick();
      f.flush = 1'b0;
      f.i_valid = 1'b0;
      f.o_ready = 1'b0;
      chk("flush_o_valid", f.o_valid, 0);
      chk("flush_count", f.o_count, 0);
      drive(5);
      #1;
      chk("postflush_no_bypass", f.o_valid, 0);
      tick();
      f.i_valid = 1'b0;
      chk("postflush_o_valid", f.o_valid, 1);
      chk("postflush_tp_label", f.o_tp_label, 8'd3);
      drain();

      // reset while full
      f.o_ready = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
         drive(r);
         tick();
      end
      chk("prerst_count", f.o_count, 4);
      rst = 1'b1;
      f.o_ready = 1'b1;
      drive(4);
      tick();
      chk("midrst_i_ready", f.i_ready, 0);
      chk("midrst_o_valid", f.o_valid, 0);
      chk("midrst_count", f.o_count, 0);
      chk("midrst_tp_label", f.o_tp_label, 0);
      chk("midrst_record", {f.o_instr, f.o_pc, f.o_class, f.o_rs1idx, f.o_rs2idx, f.o_rdidx}, 0);
      chk("midrst_flags", {f.o_prdt_taken, f.o_rs1en, f.o_rs2en, f.o_rdwen,
                           f.o_new_timepoint, f.o_measure, f.o_fmr, f.o_illegal}, 0);
      tick();
      chk("rst_held_i_ready", f.i_ready, 0);
      rst = 1'b0;
      f.i_valid = 1'b0;
      f.o_ready = 1'b0;
      #1;
      chk("rst_release_i_ready", f.i_ready, 1);

      // quantum decode disabled
      g.i_valid = 1'b1;
      g.i_instr = vec[10].instr;
      tick();
      g.i_instr = vec[0].instr;
      tick();
      g.i_valid = 1'b0;
      chk("nq_count", g.o_count, 2);
      chk("nq_illegal", g.o_illegal, 1);
      chk("nq_class", g.o_class, 0);
      chk("nq_en_flags", {g.o_rs1en, g.o_rs2en, g.o_rdwen, g.o_new_timepoint, g.o_measure, g.o_fmr}, 0);
      g.o_ready = 1'b1;
      tick();
      chk("nq_classical_class", g.o_class, 9'h008);
      chk("nq_classical_illegal", g.o_illegal, 0);
      tick();
      chk("nq_drained", g.o_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
